fpga_conf_sequencer: RTL and testbench

Parametrised configuration sequencer for NCH downstream FPGAs (GLITC-class), each with its own PROGRAM_B/INIT_B/DONE pins, driven from a WISHBONE-style register slave.
Each channel has an independent state machine with these phases:
- pulse PROGRAM_B for a programmable width;
- wait for INIT_B release, with timeout;
- wait for DONE while the bitstream is loaded over the separate GLITCBUS path, with timeout;
- report ready or error.
gready_o feeds the downstream bus logic so that only configured FPGAs are accessed.

---
 rtl/conf_seq_pkg.sv | 42 ++++
 rtl/conf_chan_fsm.sv | 150 +++++++++++++++
 rtl/fpga_conf_sequencer.sv | 107 ++++++++++
 tb/tb_fpga_conf_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conf_seq_pkg.sv
// Shared types and constants for the FPGA configuration sequencer.
// Holds the per-channel state encoding, error cause codes, register map
// and the bit layout of the control/status register.
package conf_seq_pkg;

  localparam int unsigned MAX_CH  = 8;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned CAUSE_W = 2;
  localparam int unsigned ADR_W   = 4;
  localparam int unsigned DAT_W   = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PROG      = 3'd1,
    ST_WAIT_INIT = 3'd2,
    ST_CONFIG    = 3'd3,
    ST_READY     = 3'd4,
    ST_ERROR     = 3'd5
  } conf_state_e;

  typedef enum logic [1:0] {
    ERR_INIT_TO = 2'd0,
    ERR_DONE_TO = 2'd1,
    ERR_CRC     = 2'd2
  } err_cause_e;

  localparam logic [ADR_W-1:0] ADR_CTRL  = 4'd0;
  localparam logic [ADR_W-1:0] ADR_STATE = 4'd1;
  localparam logic [ADR_W-1:0] ADR_ERR   = 4'd2;

  localparam int unsigned START_LSB = 0;
  localparam int unsigned ABORT_LSB = 16;

  // Readback layout of the control register, MSB first.
  typedef struct packed {
    logic [MAX_CH-1:0] err;
    logic [MAX_CH-1:0] done;
    logic [MAX_CH-1:0] init;
    logic [MAX_CH-1:0] busy;
  } ctrl_status_t;

endpackage

// File: rtl/conf_chan_fsm.sv
// One configuration channel: INIT_B/DONE synchronisers, phase counter and
// the PROGRAM_B / INIT_B / DONE sequencing FSM.
// Optional macro CONF_INIT_ERR_EN: INIT_B low while loading is a CRC error.
// Ports:
//   clk_i, rst_n_i      clock, async active-low reset
//   start_i, abort_i    one-cycle command pulses (abort has priority)
//   init_b_i, done_i    raw asynchronous pins
//   prog_b_o            PROGRAM_B pin (registered, active low)
//   gready_o            channel configured (registered)
//   init_s_o, done_s_o  synchronised pin values
//   state_o             current state code
//   err_cause_o         last error cause
module conf_chan_fsm
  import conf_seq_pkg::*;
#(
  parameter int unsigned PROG_CYCLES  = 16,
  parameter int unsigned INIT_TIMEOUT = 65535,
  parameter int unsigned DONE_TIMEOUT = 24'hFF_FFFF,
  parameter int unsigned CNT_W        = 24
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               init_b_i,
  input  logic               done_i,
  output logic               prog_b_o,
  output logic               gready_o,
  output logic               init_s_o,
  output logic               done_s_o,
  output logic [STATE_W-1:0] state_o,
  output logic [CAUSE_W-1:0] err_cause_o
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] PROG_LAST = CNT_W'(PROG_CYCLES - 1);
  localparam logic [CNT_W-1:0] INIT_LIM  = CNT_W'(INIT_TIMEOUT);
  localparam logic [CNT_W-1:0] DONE_LIM  = CNT_W'(DONE_TIMEOUT);

  logic [1:0]       init_sync_q, done_sync_q;
  logic             init_s, done_s;
  conf_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  err_cause_e       cause_q, cause_d;
  logic             prog_b_q, gready_q;

  // Two-flop synchronisers for the asynchronous pins.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      init_sync_q <= 2'b00;
      done_sync_q <= 2'b00;
    end else begin
      init_sync_q <= {init_sync_q[0], init_b_i};
      done_sync_q <= {done_sync_q[0], done_i};
    end
  end

  assign init_s = init_sync_q[1];
  assign done_s = done_sync_q[1];

  // Saturating increment; the counter never wraps.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // State register plus registered pin outputs decoded from the next state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cause_q  <= ERR_INIT_TO;
      prog_b_q <= 1'b1;
      gready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cause_q  <= cause_d;
      prog_b_q <= (state_d != ST_PROG);
      gready_q <= (state_d == ST_READY);
    end
  end

  // Next-state logic; commands override the phase sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    if (abort_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      cause_d = ERR_INIT_TO;
    end else if (start_i) begin
      state_d = ST_PROG;
      cnt_d   = '0;
      cause_d = ERR_INIT_TO;
    end else begin
      case (state_q)
        ST_PROG: begin
          if (cnt_q == PROG_LAST) begin
            state_d = ST_WAIT_INIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_WAIT_INIT: begin
          if (init_s) begin
            state_d = ST_CONFIG;
            cnt_d   = '0;
          end else if (cnt_q == INIT_LIM) begin
            state_d = ST_ERROR;
            cause_d = ERR_INIT_TO;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_CONFIG: begin
          if (done_s) begin
            state_d = ST_READY;
          end
`ifdef CONF_INIT_ERR_EN
          else if (!init_s) begin
            state_d = ST_ERROR;
            cause_d = ERR_CRC;
          end
`endif
          else if (cnt_q == DONE_LIM) begin
            state_d = ST_ERROR;
            cause_d = ERR_DONE_TO;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_READY: begin
          if (!done_s) begin
            state_d = ST_ERROR;
            cause_d = ERR_DONE_TO;
          end
        end
        default: ;
      endcase
    end
  end

  assign prog_b_o    = prog_b_q;
  assign gready_o    = gready_q;
  assign init_s_o    = init_s;
  assign done_s_o    = done_s;
  assign state_o     = state_q;
  assign err_cause_o = cause_q;

endmodule

// File: rtl/fpga_conf_sequencer.sv
// Configuration sequencer for NCH downstream FPGAs behind a zero-wait
// WISHBONE-style register slave. Owns bus decode and readback; each FPGA is
// handled by an independent conf_chan_fsm.
// Optional macro CONF_INIT_ERR_EN: enables CRC error detection and the
// err_cause readback register at address 2.
// Ports:
//   clk_i, rst_n_i                  clock, async active-low reset
//   cyc_i, stb_i, we_i, adr_i, dat_i  bus request
//   dat_o, ack_o                    combinational read data / acknowledge
//   gready_o                        per-channel configured flag
//   PROGRAM_B                       active-low program pins
//   INIT_B, DONE                    asynchronous FPGA status pins
module fpga_conf_sequencer
  import conf_seq_pkg::*;
#(
  parameter int unsigned NCH          = 4,
  parameter int unsigned PROG_CYCLES  = 16,
  parameter int unsigned INIT_TIMEOUT = 65535,
  parameter int unsigned DONE_TIMEOUT = 24'hFF_FFFF,
  parameter int unsigned CNT_W        = 24
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             cyc_i,
  input  logic             stb_i,
  input  logic             we_i,
  input  logic [3:0]       adr_i,
  input  logic [31:0]      dat_i,
  output logic [31:0]      dat_o,
  output logic             ack_o,
  output logic [NCH-1:0]   gready_o,
  output logic [NCH-1:0]   PROGRAM_B,
  input  logic [NCH-1:0]   INIT_B,
  input  logic [NCH-1:0]   DONE
);

  logic                     wr_c;
  logic [NCH-1:0]           start_c, abort_c;
  logic [NCH-1:0]           init_s, done_s;
  logic [NCH*STATE_W-1:0]   state_w;
  logic [NCH*CAUSE_W-1:0]   cause_w;
  ctrl_status_t             status_c;
  logic [MAX_CH*STATE_W-1:0] state_word_c;

  assign ack_o   = cyc_i & stb_i;
  assign wr_c    = cyc_i & stb_i & we_i & (adr_i == ADR_CTRL);
  assign start_c = wr_c ? dat_i[START_LSB +: NCH] : '0;
  assign abort_c = wr_c ? dat_i[ABORT_LSB +: NCH] : '0;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    conf_chan_fsm #(
      .PROG_CYCLES  (PROG_CYCLES),
      .INIT_TIMEOUT (INIT_TIMEOUT),
      .DONE_TIMEOUT (DONE_TIMEOUT),
      .CNT_W        (CNT_W)
    ) u_chan (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .start_i     (start_c[g]),
      .abort_i     (abort_c[g]),
      .init_b_i    (INIT_B[g]),
      .done_i      (DONE[g]),
      .prog_b_o    (PROGRAM_B[g]),
      .gready_o    (gready_o[g]),
      .init_s_o    (init_s[g]),
      .done_s_o    (done_s[g]),
      .state_o     (state_w[g*STATE_W +: STATE_W]),
      .err_cause_o (cause_w[g*CAUSE_W +: CAUSE_W])
    );
  end

  // Gather per-channel status into the readback words.
  always_comb begin
    status_c     = '0;
    state_word_c = '0;
    for (int i = 0; i < NCH; i++) begin
      status_c.busy[i] = (state_w[i*STATE_W +: STATE_W] == ST_PROG) ||
                         (state_w[i*STATE_W +: STATE_W] == ST_WAIT_INIT) ||
                         (state_w[i*STATE_W +: STATE_W] == ST_CONFIG);
      status_c.err[i]  = (state_w[i*STATE_W +: STATE_W] == ST_ERROR);
      status_c.init[i] = init_s[i];
      status_c.done[i] = done_s[i];
      state_word_c[i*STATE_W +: STATE_W] = state_w[i*STATE_W +: STATE_W];
    end
  end

  // Combinational read mux.
  always_comb begin
    dat_o = '0;
    case (adr_i)
      ADR_CTRL:  dat_o = status_c;
      ADR_STATE: dat_o = 32'(state_word_c);
`ifdef CONF_INIT_ERR_EN
      ADR_ERR:   dat_o = 32'(cause_w);
`endif
      default:   dat_o = '0;
    endcase
  end

`ifndef CONF_INIT_ERR_EN
  logic unused_cause_c;
  assign unused_cause_c = ^cause_w;
`endif
  logic unused_dat_c;
  assign unused_dat_c = ^dat_i;

endmodule

// File: tb/tb_fpga_conf_sequencer.sv
// Self-checking bench for fpga_conf_sequencer: directed scenarios plus a
// randomized phase, all checked against a phase/elapsed-time reference model.
`timescale 1ns/1ps
module tb_fpga_conf_sequencer;

  localparam int unsigned NCH = 4;
  localparam int unsigned PC  = 16;
  localparam int unsigned IT  = 100;
  localparam int unsigned DT  = 600;

  logic           clk_i = 1'b0;
  logic           rst_n_i = 1'b0;
  logic           cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [3:0]     adr_i = 4'd0;
  logic [31:0]    dat_i = 32'd0;
  logic [31:0]    dat_o;
  logic           ack_o;
  logic [NCH-1:0] gready_o, PROGRAM_B;
  logic [NCH-1:0] INIT_B = '0, DONE = '0;

  always #10 clk_i = ~clk_i;

  fpga_conf_sequencer #(
    .NCH(NCH), .PROG_CYCLES(PC), .INIT_TIMEOUT(IT), .DONE_TIMEOUT(DT), .CNT_W(24)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o),
    .gready_o(gready_o), .PROGRAM_B(PROGRAM_B), .INIT_B(INIT_B), .DONE(DONE)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: phase number (0 idle,1 prog,2 wait_init,3 config,
  // 4 ready,5 error) and the clock edge on which the phase was entered.
  int m_ph[NCH];
  int m_ent[NCH];
  int m_cause[NCH];
  int edge_n = 0;
  int m_el;
  logic m_wr;
  logic [NCH-1:0] ih0 = '0, ih1 = '0, dh0 = '0, dh1 = '0;

  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      edge_n = 0;
      for (int i = 0; i < NCH; i++) begin
        m_ph[i] = 0; m_ent[i] = 0; m_cause[i] = 0;
      end
      ih0 = '0; ih1 = '0; dh0 = '0; dh1 = '0;
    end else begin
      edge_n++;
      m_wr = cyc_i && stb_i && we_i && (adr_i == 4'd0);
      for (int i = 0; i < NCH; i++) begin
        m_el = edge_n - m_ent[i];
        if (m_wr && dat_i[16+i]) begin
          m_ph[i] = 0; m_cause[i] = 0;
        end else if (m_wr && dat_i[i]) begin
          m_ph[i] = 1; m_ent[i] = edge_n; m_cause[i] = 0;
        end else begin
          case (m_ph[i])
            1: if (m_el == PC) begin m_ph[i] = 2; m_ent[i] = edge_n; end
            2: if (ih1[i]) begin m_ph[i] = 3; m_ent[i] = edge_n; end
               else if (m_el == IT + 1) begin m_ph[i] = 5; m_cause[i] = 0; end
            3: if (dh1[i]) m_ph[i] = 4;
`ifdef CONF_INIT_ERR_EN
               else if (!ih1[i]) begin m_ph[i] = 5; m_cause[i] = 2; end
`endif
               else if (m_el == DT + 1) begin m_ph[i] = 5; m_cause[i] = 1; end
            4: if (!dh1[i]) begin m_ph[i] = 5; m_cause[i] = 1; end
            default: ;
          endcase
        end
      end
      ih1 = ih0; ih0 = INIT_B;
      dh1 = dh0; dh0 = DONE;
    end
  end

  logic [31:0] st_word = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    adr_i = a;
    #1;
    d = dat_o;
  endtask

  task automatic check_all();
    logic [31:0] e0, e1, e2, v;
    logic [NCH-1:0] epb, egr;
    e0 = '0; e1 = '0; e2 = '0; epb = '0; egr = '0;
    for (int i = 0; i < NCH; i++) begin
      e0[i]      = (m_ph[i] >= 1) && (m_ph[i] <= 3);
      e0[8+i]    = ih1[i];
      e0[16+i]   = dh1[i];
      e0[24+i]   = (m_ph[i] == 5);
      e1[3*i +: 3] = 3'(m_ph[i]);
`ifdef CONF_INIT_ERR_EN
      e2[2*i +: 2] = 2'(m_cause[i]);
`endif
      epb[i] = (m_ph[i] != 1);
      egr[i] = (m_ph[i] == 4);
    end
    rd(4'd0, v); chk("adr0_status", v, e0);
    rd(4'd1, v); st_word = v; chk("adr1_state", v, e1);
    rd(4'd2, v); chk("adr2_cause", v, e2);
    rd(4'($urandom_range(3, 15)), v); chk("adr_unmapped", v, 32'd0);
    chk("program_b", 32'(PROGRAM_B), 32'(epb));
    chk("gready", 32'(gready_o), 32'(egr));
    chk("ack_idle", 32'(ack_o), 32'd0);
    adr_i = 4'd0;
  endtask

  task automatic tick();
    @(negedge clk_i);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    check_all();
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    adr_i = a; dat_i = d; we_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1;
    #1;
    chk("ack_write", 32'(ack_o), 32'd1);
    tick();
  endtask

  function automatic logic [2:0] state_of(input int ch);
    return st_word[3*ch +: 3];
  endfunction

  task automatic wait_state(input int ch, input logic [2:0] val, input int limit, input string tag);
    int n;
    n = 0;
    while (state_of(ch) != val && n < limit) begin
      tick();
      n++;
    end
    chk(tag, 32'(state_of(ch)), 32'(val));
  endtask

  task automatic pulse_width(input int ch, output int n);
    n = 0;
    while (PROGRAM_B[ch] == 1'b0 && n < 100) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] v, d, r;

    // Reset values
    tick(); tick();
    chk("rst_program_b", 32'(PROGRAM_B), 32'hF);
    chk("rst_gready", 32'(gready_o), 32'h0);
    chk("rst_states", st_word, 32'h0);
    rst_n_i = 1'b1;
    tick();

    // Channel 0 full sequence
    bus_write(4'd0, 32'h1);
    pulse_width(0, n);
    chk("t1_pulse_width", 32'(n), 32'd16);
    chk("t1_wait_init", 32'(state_of(0)), 32'd2);
    repeat (9) tick();
    INIT_B[0] = 1'b1;
    wait_state(0, 3'd3, 10, "t1_to_config");
    repeat (100) tick();
    DONE[0] = 1'b1;
    wait_state(0, 3'd4, 10, "t1_to_ready");
    chk("t1_gready", 32'(gready_o), 32'h1);
    rd(4'd0, v);
    chk("t1_adr0", v, 32'h0001_0100);

    // Channel 2 init timeout
    bus_write(4'd0, 32'h4);
    wait_state(2, 3'd2, 30, "t2_enter_wait_init");
    n = 0;
    while (state_of(2) == 3'd2 && n < 300) begin
      n++;
      tick();
    end
    chk("t2_wait_init_cycles", 32'(n), 32'd101);
    chk("t2_state_error", 32'(state_of(2)), 32'd5);
    rd(4'd0, v);
    chk("t2_err_bits", 32'(v[31:24]), 32'h04);
    chk("t2_ch0_unaffected", 32'(state_of(0)), 32'd4);

    // Abort wins over start; restart during CONFIG
    bus_write(4'd0, 32'h0001_0001);
    chk("t3_abort_wins", 32'(state_of(0)), 32'd0);
    chk("t3_prog_b_high", 32'(PROGRAM_B[0]), 32'd1);
    tick();
    chk("t3_still_idle", 32'(state_of(0)), 32'd0);
    DONE[0] = 1'b0;
    tick();
    bus_write(4'd0, 32'h1);
    wait_state(0, 3'd3, 40, "t3_config");
    repeat (5) tick();
    bus_write(4'd0, 32'h1);
    pulse_width(0, n);
    chk("t3_repulse_width", 32'(n), 32'd16);

    // Simultaneous start, staggered DONE
    bus_write(4'd0, 32'h000F_0000);
    INIT_B = '0; DONE = '0;
    tick(); tick();
    bus_write(4'd0, 32'hF);
    wait_state(3, 3'd2, 30, "t4_wait_init");
    INIT_B = '1;
    wait_state(3, 3'd3, 10, "t4_config");
    for (int i = 0; i < NCH; i++) begin
      repeat ($urandom_range(1, 20)) tick();
      DONE[i] = 1'b1;
      repeat (3) tick();
      chk("t4_gready_stagger", 32'(gready_o), (32'd1 << (i + 1)) - 32'd1);
    end
    DONE[1] = 1'b0;
    repeat (3) tick();
    chk("t4_gready_drop", 32'(gready_o), 32'hD);
    chk("t4_ch1_error", 32'(state_of(1)), 32'd5);

    // Randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        n = int'($urandom_range(0, NCH - 1));
        INIT_B[n] = ~INIT_B[n];
      end
      if ($urandom_range(0, 9) == 0) begin
        n = int'($urandom_range(0, NCH - 1));
        DONE[n] = ~DONE[n];
      end
      if ($urandom_range(0, 39) == 0) begin
        d = $urandom; r = $urandom;
        d[19:16] = d[19:16] & r[3:0] & r[7:4];
        bus_write(($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0, d);
      end else begin
        tick();
      end
    end

    // Asynchronous reset while programming
    INIT_B = '0; DONE = '0;
    bus_write(4'd0, 32'hF);
    repeat (3) tick();
    chk("t5_in_prog", 32'(PROGRAM_B), 32'h0);
    #2 rst_n_i = 1'b0;
    #1;
    chk("t5_async_prog_b", 32'(PROGRAM_B), 32'hF);
    chk("t5_gready", 32'(gready_o), 32'h0);
    rd(4'd1, v);
    chk("t5_states", v, 32'h0);
    tick(); tick();
    rst_n_i = 1'b1;
    tick();

    // INIT_B low during CONFIG on channel 3
    INIT_B = 4'h8; DONE = '0;
    tick();
    bus_write(4'd0, 32'h8);
    wait_state(3, 3'd3, 40, "t6_config");
    repeat (3) tick();
    INIT_B[3] = 1'b0;
    repeat (4) tick();
`ifdef CONF_INIT_ERR_EN
    chk("t6_crc_error", 32'(state_of(3)), 32'd5);
    rd(4'd2, v);
    chk("t6_cause", 32'(v[7:6]), 32'd2);
`else
    chk("t6_stays_config", 32'(state_of(3)), 32'd3);
    rd(4'd2, v);
    chk("t6_adr2_zero", v, 32'd0);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
